// File: rtl/beep_sequencer.sv
// Level-dependent beep pattern generator with a timed mute.
// One clock domain, synchronous active-high reset, registered outputs.
module beep_sequencer #(
    parameter int TICK_DIV   = 1000,
    parameter int MUTE_TICKS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] level,
    input  logic       mute_pulse,
    output logic       beeper,
    output logic       muted,
    output logic [1:0] seq_state
);

    localparam int TW = $clog2(TICK_DIV);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [7:0]    MUTE_LOAD = 8'(MUTE_TICKS);
    localparam logic [2:0]    LEVEL_CONT = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ON    = 2'b01,
        OFF   = 2'b10,
        MUTED = 2'b11
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [2:0]    level_q;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    phase_cnt;
    logic [2:0]    phase_next;
    logic [7:0]    mute_cnt;
    logic [7:0]    mute_next;
    logic          tick;
    logic          tick_clr;
    logic          level_chg;

    function automatic logic [2:0] on_ticks(input logic [2:0] lvl);
        case (lvl)
            3'd4:    on_ticks = 3'd2;
            3'd5:    on_ticks = 3'd3;
            default: on_ticks = 3'd1;
        endcase
    endfunction

    function automatic logic [2:0] off_ticks(input logic [2:0] lvl);
        case (lvl)
            3'd1:    off_ticks = 3'd7;
            3'd2:    off_ticks = 3'd5;
            3'd3:    off_ticks = 3'd3;
            3'd4:    off_ticks = 3'd2;
            default: off_ticks = 3'd1;
        endcase
    endfunction

    assign tick      = (tick_cnt == TICK_LAST);
    assign level_chg = (level != level_q);
    assign seq_state = state;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case can leave one unassigned and infer a latch.
        next_state = state;
        phase_next = phase_cnt;
        mute_next  = mute_cnt;
        tick_clr   = 1'b0;

        unique case (state)
            IDLE: begin
                if (level_chg && level != 3'd0) begin
                    next_state = ON;
                    phase_next = on_ticks(level);
                end
            end

            ON, OFF: begin
                if (level_chg) begin
                    if (level == 3'd0) begin
                        next_state = IDLE;
                    end else begin
                        // Restart of the pattern, possibly ON -> ON.
                        next_state = ON;
                        phase_next = on_ticks(level);
                        tick_clr   = 1'b1;
                    end
                end else if (mute_pulse) begin
                    next_state = MUTED;
                    mute_next  = MUTE_LOAD;
                end else if (tick && !(state == ON && level_q == LEVEL_CONT)) begin
                    if (phase_cnt <= 3'd1) begin
                        if (state == ON) begin
                            next_state = OFF;
                            phase_next = off_ticks(level_q);
                        end else begin
                            next_state = ON;
                            phase_next = on_ticks(level_q);
                        end
                    end else begin
                        phase_next = phase_cnt - 3'd1;
                    end
                end
            end

            MUTED: begin
                if (level_chg && level > level_q) begin
                    next_state = ON;
                    phase_next = on_ticks(level);
                    mute_next  = 8'd0;
                end else if (level_chg && level == 3'd0) begin
                    next_state = IDLE;
                    mute_next  = 8'd0;
                end else if (!level_chg && mute_pulse) begin
                    mute_next = MUTE_LOAD;
                    tick_clr  = 1'b1;
                end else if (tick) begin
                    // A decrease to a nonzero level falls through here and
                    // keeps the running mute timer.
                    if (mute_cnt <= 8'd1) begin
                        mute_next = 8'd0;
                        if (level != 3'd0) begin
                            next_state = ON;
                            phase_next = on_ticks(level);
                        end else begin
                            next_state = IDLE;
                        end
                    end else begin
                        mute_next = mute_cnt - 8'd1;
                    end
                end
            end
        endcase

        if (next_state != state) begin
            tick_clr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state     <= IDLE;
            level_q   <= 3'd0;
            tick_cnt  <= '0;
            phase_cnt <= 3'd0;
            mute_cnt  <= 8'd0;
            beeper    <= 1'b0;
            muted     <= 1'b0;
        end else begin
            state     <= next_state;
            level_q   <= level;
            phase_cnt <= phase_next;
            mute_cnt  <= mute_next;
            if (tick_clr || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            // Decoded from next_state so the outputs move with seq_state.
            beeper <= (next_state == ON);
            muted  <= (next_state == MUTED);
        end
    end

endmodule
